// File: rtl/out_pixel_buffer_pkg.sv
// Shared types and constants for the Sobel output pixel buffer.
package outbuf_pkg;

    localparam int WORD_W       = 32;
    localparam int PIX_PER_WORD = 32;
    localparam int ADDR_STEP    = 4;

    typedef enum logic [1:0] {
        DR_IDLE,
        DR_REQ,
        DR_FLUSH
    } drain_state_t;

endpackage

// File: rtl/out_pixel_buffer_sync_word_fifo.sv
// Small synchronous FIFO with first-word-fall-through head and occupancy count.
module sync_word_fifo #(
    parameter int DEPTH  = 4,
    parameter int WORD_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WORD_W-1:0]          din,
    output logic [WORD_W-1:0]          dout,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    // Storage holds data only; emptiness is tracked by pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (push && !pop)      r_count <= r_count + 1'b1;
            else if (pop && !push) r_count <= r_count - 1'b1;
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule

// File: rtl/out_pixel_buffer.sv
// Packs 1-bit edge pixels into 32-bit words, buffers them and drains them to the write port.
// Optional feature: define OUT_PIXEL_BUFFER_COUNT_EN to add the edge_count output.
module out_pixel_buffer
    import outbuf_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              out_en,
    input  logic              out_pixel,
    input  logic              write_out_enable,
    output logic              out_full,
    output logic              out_empty,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    input  logic              wr_ack,
    output logic              overflow
`ifdef OUT_PIXEL_BUFFER_COUNT_EN
    ,
    output logic [31:0]       edge_count
`endif
);

    localparam int CNT_W = $clog2(DEPTH+1);

    drain_state_t      r_state;
    logic [WORD_W-1:0] r_pack;
    logic [4:0]        r_pix_cnt;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_overflow;

    logic [CNT_W-1:0]  w_count;
    logic [WORD_W-1:0] w_head;
    logic              w_accept;
    logic              w_last;
    logic [WORD_W-1:0] w_word;
    logic              w_push;
    logic              w_pop;
    logic              w_flush_ack;
    logic              w_fifo_drained;
    logic [WORD_W-1:0] w_pack_nxt;
    logic [4:0]        w_pix_cnt_nxt;

    sync_word_fifo #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_word),
        .dout  (w_head),
        .count (w_count)
    );

    assign w_accept       = out_en && !out_full;
    assign w_last         = (r_pix_cnt == 5'(PIX_PER_WORD - 1));
    assign w_word         = r_pack | (WORD_W'(out_pixel) << r_pix_cnt);
    assign w_push         = w_accept && w_last;
    assign w_pop          = (r_state == DR_REQ) && wr_ack;
    assign w_flush_ack    = (r_state == DR_FLUSH) && wr_ack;
    // Last word leaves only if no completed word refills the FIFO on the same edge.
    assign w_fifo_drained = (w_count == CNT_W'(1)) && !w_push;

    always_comb begin
        w_pack_nxt    = r_pack;
        w_pix_cnt_nxt = r_pix_cnt;
        if (w_flush_ack) begin
            w_pack_nxt    = '0;
            w_pix_cnt_nxt = '0;
        end else if (w_accept) begin
            w_pack_nxt    = w_last ? '0 : w_word;
            w_pix_cnt_nxt = w_last ? 5'd0 : r_pix_cnt + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= DR_IDLE;
            r_pack     <= '0;
            r_pix_cnt  <= '0;
            r_wr_addr  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_pack    <= w_pack_nxt;
            r_pix_cnt <= w_pix_cnt_nxt;
            if (out_en && out_full) r_overflow <= 1'b1;
            case (r_state)
                DR_IDLE: begin
                    if (start) r_wr_addr <= base_addr;
                    if (write_out_enable) begin
                        if (w_count != '0)        r_state <= DR_REQ;
                        else if (r_pix_cnt != '0) r_state <= DR_FLUSH;
                    end
                end
                DR_REQ: begin
                    if (wr_ack) begin
                        r_wr_addr <= r_wr_addr + ADDR_W'(ADDR_STEP);
                        if (w_fifo_drained) begin
                            r_state <= (w_pix_cnt_nxt != '0) ? DR_FLUSH : DR_IDLE;
                        end
                    end
                end
                DR_FLUSH: begin
                    if (wr_ack) begin
                        r_wr_addr <= r_wr_addr + ADDR_W'(ADDR_STEP);
                        r_state   <= DR_IDLE;
                    end
                end
                default: r_state <= DR_IDLE;
            endcase
        end
    end

    assign out_full  = (w_count == CNT_W'(DEPTH)) || (r_state == DR_FLUSH);
    assign out_empty = (w_count == '0) && (r_pix_cnt == '0) && (r_state == DR_IDLE);
    assign wr_req    = (r_state != DR_IDLE);
    assign wr_addr   = r_wr_addr;
    assign wr_data   = (r_state == DR_REQ)   ? w_head :
                       (r_state == DR_FLUSH) ? r_pack : '0;
    assign overflow  = r_overflow;

`ifdef OUT_PIXEL_BUFFER_COUNT_EN
    logic [31:0] r_edge_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_edge_count <= '0;
        end else if (start && (r_state == DR_IDLE)) begin
            r_edge_count <= '0;
        end else if (w_accept && out_pixel && (r_edge_count != '1)) begin
            r_edge_count <= r_edge_count + 32'd1;
        end
    end

    assign edge_count = r_edge_count;
`endif

endmodule

// File: tb/tb_out_pixel_buffer.sv
// Directed bench for out_pixel_buffer with a write scoreboard fed by a pixel-packing model.
module tb_out_pixel_buffer;

    localparam int          DEPTH  = 4;
    localparam int          ADDR_W = 32;
    localparam logic [31:0] BASE   = 32'h0000_1000;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              out_en;
    logic              out_pixel;
    logic              write_out_enable;
    logic              out_full;
    logic              out_empty;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              wr_ack;
    logic              overflow;
`ifdef OUT_PIXEL_BUFFER_COUNT_EN
    logic [31:0]       edge_count;
`endif

    out_pixel_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .base_addr        (base_addr),
        .out_en           (out_en),
        .out_pixel        (out_pixel),
        .write_out_enable (write_out_enable),
        .out_full         (out_full),
        .out_empty        (out_empty),
        .wr_req           (wr_req),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .wr_ack           (wr_ack),
        .overflow         (overflow)
`ifdef OUT_PIXEL_BUFFER_COUNT_EN
        ,
        .edge_count       (edge_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_pack   = '0;
    int          m_cnt    = 0;
    logic [31:0] m_addr   = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Every accepted write must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && wr_req && wr_ack) begin
            n_checks++;
            assert (sb_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_write: observed addr %h data %h expected no write", wr_addr, wr_data);
            end
            if (sb_q.size() != 0) begin
                wr_t e;
                e = sb_q.pop_front();
                check("wr_addr", wr_addr, e.addr);
                check("wr_data", wr_data, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pix(input logic b);
        wr_t e;
        out_en    = 1'b1;
        out_pixel = b;
        m_pack[m_cnt] = b;
        m_cnt++;
        if (m_cnt == 32) begin
            e.addr = m_addr;
            e.data = m_pack;
            sb_q.push_back(e);
            m_addr += 4;
            m_pack  = '0;
            m_cnt   = 0;
        end
        tick();
        out_en = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start  = 1'b0;
        m_addr = BASE;
    endtask

    task automatic drain_req();
        wr_t e;
        if (m_cnt > 0) begin
            e.addr = m_addr;
            e.data = m_pack;
            sb_q.push_back(e);
            m_addr += 4;
            m_pack  = '0;
            m_cnt   = 0;
        end
        write_out_enable = 1'b1;
        tick();
        write_out_enable = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!(out_empty && !wr_req) && n < 200) begin
            tick();
            n++;
        end
        n_checks++;
        assert (n < 200) else begin
            n_fail++;
            $error("FAIL %s_timeout: observed %0d cycles expected < 200", tag, n);
        end
        check({tag, "_sb_left"}, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        rst              = 1'b1;
        start            = 1'b0;
        base_addr        = BASE;
        out_en           = 1'b0;
        out_pixel        = 1'b0;
        write_out_enable = 1'b0;
        wr_ack           = 1'b0;
        tick();
        tick();
        check("rst_out_full",  32'(out_full),  32'd0);
        check("rst_out_empty", 32'(out_empty), 32'd1);
        check("rst_wr_req",    32'(wr_req),    32'd0);
        check("rst_wr_addr",   wr_addr,        32'd0);
        check("rst_wr_data",   wr_data,        32'd0);
        check("rst_overflow",  32'(overflow),  32'd0);
        rst = 1'b0;
        tick();

        // One alternating word, drained with ack held high.
        do_start();
        for (int i = 0; i < 32; i++) send_pix((i % 2) == 0);
        check("t1_out_empty", 32'(out_empty), 32'd0);
        check("t1_out_full",  32'(out_full),  32'd0);
`ifdef OUT_PIXEL_BUFFER_COUNT_EN
        check("t1_edge_count", edge_count, 32'd16);
`endif
        wr_ack = 1'b1;
        drain_req();
        wait_idle("t1");
        wr_ack = 1'b0;
        check("t1_empty_after", 32'(out_empty), 32'd1);
        check("t1_addr_after",  wr_addr,        BASE + 32'd4);

        // Fill FIFO, then one dropped pixel.
        do_start();
        for (int i = 0; i < DEPTH * 32; i++) send_pix(1'($urandom_range(0, 1)));
        check("t2_out_full",     32'(out_full), 32'd1);
        check("t2_overflow_pre", 32'(overflow), 32'd0);
        out_en    = 1'b1;
        out_pixel = 1'b1;
        tick();
        out_en = 1'b0;
        check("t2_overflow",   32'(overflow), 32'd1);
        check("t2_still_full", 32'(out_full), 32'd1);
        wr_ack = 1'b1;
        drain_req();
        wait_idle("t2");
        wr_ack = 1'b0;

        // Partial word flush.
        do_start();
        for (int i = 0; i < 5; i++) send_pix(1'b1);
        drain_req();
        check("t3_wr_req",   32'(wr_req),   32'd1);
        check("t3_out_full", 32'(out_full), 32'd1);
        check("t3_wr_data",  wr_data,       32'h0000_001F);
        check("t3_wr_addr",  wr_addr,       BASE);
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        check("t3_out_full_after", 32'(out_full),  32'd0);
        check("t3_empty_after",    32'(out_empty), 32'd1);

        // Two words plus partial with slow ack: outputs must hold while waiting.
        do_start();
        for (int i = 0; i < 67; i++) send_pix(1'($urandom_range(0, 1)));
        drain_req();
        for (int w = 0; w < 3; w++) begin
            for (int k = 0; k < 3; k++) begin
                check("t4_wait_req",  32'(wr_req), 32'd1);
                check("t4_wait_addr", wr_addr,     BASE + 32'(4 * w));
                check("t4_wait_data", wr_data,     sb_q[0].data);
                tick();
            end
            wr_ack = 1'b1;
            tick();
            wr_ack = 1'b0;
        end
        wait_idle("t4");

        // Push and pop on the same edge during a drain.
        do_start();
        for (int i = 0; i < 96; i++) send_pix(1'($urandom_range(0, 1)));
        drain_req();
        for (int i = 0; i < 31; i++) send_pix(1'($urandom_range(0, 1)));
        wr_ack = 1'b1;
        send_pix(1'($urandom_range(0, 1)));
        wr_ack = 1'b0;
        check("t5_out_full", 32'(out_full), 32'd0);
        check("t5_wr_req",   32'(wr_req),   32'd1);
        wr_ack = 1'b1;
        wait_idle("t5");
        wr_ack = 1'b0;

        // Reset in the middle of a drain.
        do_start();
        for (int i = 0; i < 32; i++) send_pix(1'($urandom_range(0, 1)));
        drain_req();
        check("t6_wr_req_pre", 32'(wr_req), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb_q.delete();
        m_pack = '0;
        m_cnt  = 0;
        check("t6_wr_req",    32'(wr_req),    32'd0);
        check("t6_out_empty", 32'(out_empty), 32'd1);
        check("t6_wr_addr",   wr_addr,        32'd0);
        check("t6_overflow",  32'(overflow),  32'd0);
        check("t6_out_full",  32'(out_full),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/out_pixel_buffer.md
# out_pixel_buffer

Downstream stage of the Sobel controller. Collects the 1-bit edge pixels the controller emits via `out_en`/`out_pixel`, packs them LSB-first into 32-bit words, and buffers those words in a small FIFO. On the controller's `write_out_enable` request it drains all buffered words, plus any partial word, to the Master/Slave write port. It returns `out_full`/`out_empty` to the controller.

## Interface
- `DEPTH`, 4: FIFO depth in 32-bit words (power of two, ≥2)
- `ADDR_W`, 32: write address width
- `clk` in 1: clock
- `rst` in 1: reset; synchronous, active-high
- `start` in 1: image start; loads `base_addr` into the write pointer when the drain FSM is in `DR_IDLE`, ignored otherwise
- `base_addr` in ADDR_W: output image base byte address
- `out_en` in 1: pixel strobe from controller
- `out_pixel` in 1: edge pixel value
- `write_out_enable` in 1: drain request pulse from controller
- `out_full` out 1: pixel input cannot be accepted
- `out_empty` out 1: FIFO empty, no partial word, drain idle
- `wr_req` out 1: write request to Master/Slave
- `wr_addr` out ADDR_W: byte address of `wr_data`
- `wr_data` out 32: packed pixel word
- `wr_ack` in 1: Master/Slave accepted current word
- `overflow` out 1: sticky; a pixel arrived while `out_full`

## Operation
- Packing
  - `pack_reg[31:0]` and `pix_cnt[4:0]`.
  - An accepted pixel (`out_en && !out_full`) writes `pack_reg[pix_cnt]` and increments `pix_cnt`.
  - On the 32nd pixel, the completed word (including that pixel) is pushed to the FIFO in the same cycle; `pack_reg` and `pix_cnt` clear.
  - `out_en` while `out_full` drops the pixel and sets `overflow`. `overflow` clears only on `rst`.
- Drain FSM: states `DR_IDLE`, `DR_REQ`, `DR_FLUSH`.
  - `DR_IDLE`: a `write_out_enable` pulse goes to `DR_REQ` if the FIFO is non-empty. Otherwise it goes to `DR_FLUSH` if `pix_cnt > 0`. Otherwise it stays in `DR_IDLE`.
  - `DR_REQ`: `wr_req`=1, `wr_data` = FIFO head. On `wr_ack`: pop, `wr_addr += 4`. If the FIFO is now empty, go to `DR_FLUSH` when `pix_cnt > 0`, else to `DR_IDLE`. Otherwise stay in `DR_REQ` (back-to-back words).
  - `DR_FLUSH`: `wr_req`=1, `wr_data` = `pack_reg` with unfilled bits zero. On `wr_ack`: clear `pack_reg`/`pix_cnt`, `wr_addr += 4`, go to `DR_IDLE`.
  - `write_out_enable` outside `DR_IDLE` is ignored.
- Flags
  - `out_full` = (FIFO count == DEPTH) || state == `DR_FLUSH`.
  - `out_empty` = FIFO count == 0 && `pix_cnt` == 0 && state == `DR_IDLE`.
- Simultaneous events
  - A push and a pop in the same cycle leave the count unchanged.
  - A word push while the FIFO is full cannot occur, because `out_full` blocks the 32nd pixel.

## Timing
- Reset values: `out_full`=0, `out_empty`=1, `wr_req`=0, `wr_addr`=0, `wr_data`=0, `overflow`=0. FSM in `DR_IDLE`; FIFO, `pack_reg` and `pix_cnt` cleared.
- `rst` mid-drain aborts the drain immediately. `wr_req` is low on the next cycle and buffered data is discarded.
- Flags are registered-state derived (no combinational path from inputs). They reflect a push or pop one cycle after the accepting edge.
- `wr_req` rises the cycle after the accepting `write_out_enable` edge.
- `wr_addr`/`wr_data` are stable while `wr_req`=1 and `wr_ack`=0. They advance on the cycle after an acked edge.
- Throughput: one word per cycle when `wr_ack` is held high.

## Configuration
- `OUT_PIXEL_BUFFER_COUNT_EN` defined: adds output `edge_count[31:0]`. It counts accepted pixels equal to 1, resets to 0 on `rst` or on an accepted `start`, and saturates at all-ones.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package `outbuf_pkg`:
  - enum `drain_state_t` {`DR_IDLE`, `DR_REQ`, `DR_FLUSH`}
  - `WORD_W`=32
  - `PIX_PER_WORD`=32
  - `ADDR_STEP`=4
- Sub-module `sync_word_fifo`:
  - Parameterised `DEPTH`/`WORD_W`.
  - Interface: `push`, `pop`, `din`, `dout` (head, first-word-fall-through), `count`.
  - Same clock and reset.

## Test plan
- Reset, then 32 pixels alternating 1,0 starting with 1 → FIFO count 1, `out_empty`=0. Pulse `write_out_enable` with `wr_ack` tied 1 → one write, `wr_data`=0x5555_5555, `wr_addr`=`base_addr`, then `out_empty`=1.
- `DEPTH`×32 pixels → `out_full`=1. One extra pixel → dropped, `overflow`=1, FIFO contents unchanged.
- 5 pixels of 1, then drain → `DR_FLUSH` write with `wr_data`=0x0000_001F. `out_full`=1 during the flush.
- 2 full words + 3 pixels, `wr_ack` delayed 3 cycles per word → `wr_addr`/`wr_data` held stable while waiting. Writes go to base, base+4, base+8; the third carries the partial word.
- Pixels pushed during `DR_REQ` with simultaneous pop → count correct, no loss, word order preserved.
- `rst` asserted while `wr_req`=1 → next cycle `wr_req`=0, `out_empty`=1, `wr_addr`=0.
